// File: rtl/dds_cfg_sequencer.sv
// dds_cfg_sequencer
//   AXI4-Lite write-only master that programs and starts the DDS register block.
//   start: latch the cfg_* profile, soft-reset the DDS, write LNGTH/CLKDIV/THETAS/
//          DELTAS/AMPLS, then set CTRL.enable. stop: write CTRL=0.
//   Each register write is one "step": AW+W issued together, then wait for B.
// Ports
//   M_AXI_ACLK / M_AXI_ARESET : clock, synchronous active-high reset
//   start, stop               : 1-cycle requests (stop wins), ignored while busy
//   cfg_*                     : tone profile, sampled on an accepted start
//   busy, done, err, err_code : status; done pulses once per sequence,
//                               err_code 00 ok / 01 BRESP error / 10 timeout
//   M_AXI_AW*/W*/B*           : AXI4-Lite write channels toward the DDS S_AXI
module dds_cfg_sequencer #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int ADDR_LSB           = 0,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              start,
  input  logic                              stop,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cfg_theta,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cfg_delta,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cfg_ampl,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cfg_clkdiv,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cfg_lngth,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [1:0]                        err_code,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int XW = AW + ADDR_LSB + 3;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] REG_CTRL = 3'd0, REG_THETAS = 3'd1, REG_DELTAS = 3'd2,
                         REG_AMPLS = 3'd3, REG_CLKDIV = 3'd4, REG_LNGTH = 3'd6;
  localparam logic [DW-1:0] CTRL_SRST = DW'(1), CTRL_EN = DW'(2);
  localparam logic [1:0] EC_OK = 2'b00, EC_RESP = 2'b01, EC_TMO = 2'b10;

  typedef enum logic [1:0] {IDLE, WR, RESP, FIN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            stop_q, stop_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [DW-1:0]   theta_q, theta_d, delta_q, delta_d, ampl_q, ampl_d;
  logic [DW-1:0]   clkdiv_q, clkdiv_d, lngth_q, lngth_d;

  logic            awvalid, wvalid, last_step, tmo_hit;
  logic [2:0]      reg_idx;
  logic [DW-1:0]   reg_data;

  // Only BRESP[1] matters: OKAY and EXOKAY are both success.
  logic unused_bresp0;
  assign unused_bresp0 = M_AXI_BRESP[0];

  assign last_step = stop_q || (step_q == 3'd7);
  // Counter starts at 0 on state entry, so the hit lands on the last allowed cycle.
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Register/value for the current step; a stop sequence is a lone CTRL=0.
  always_comb begin
    reg_idx  = REG_CTRL;
    reg_data = '0;
    if (!stop_q) begin
      case (step_q)
        3'd0: reg_data = CTRL_SRST;
        3'd1: reg_data = '0;
        3'd2: begin reg_idx = REG_LNGTH;  reg_data = lngth_q;  end
        3'd3: begin reg_idx = REG_CLKDIV; reg_data = clkdiv_q; end
        3'd4: begin reg_idx = REG_THETAS; reg_data = theta_q;  end
        3'd5: begin reg_idx = REG_DELTAS; reg_data = delta_q;  end
        3'd6: begin reg_idx = REG_AMPLS;  reg_data = ampl_q;   end
        default: reg_data = CTRL_EN;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tmo_d      = tmo_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    stop_d     = stop_q;
    err_code_d = err_code_q;
    theta_d    = theta_q;
    delta_d    = delta_q;
    ampl_d     = ampl_q;
    clkdiv_d   = clkdiv_q;
    lngth_d    = lngth_q;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    M_AXI_BREADY = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || stop) begin
          state_d    = WR;
          step_d     = '0;
          tmo_d      = '0;
          err_code_d = EC_OK;
          stop_d     = stop;
          if (!stop) begin
            theta_d  = cfg_theta;
            delta_d  = cfg_delta;
            ampl_d   = cfg_ampl;
            clkdiv_d = cfg_clkdiv;
            lngth_d  = cfg_lngth;
          end
        end
      end
      WR: begin
        busy    = 1'b1;
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        tmo_d   = tmo_q + TW'(1);
        if (awvalid && M_AXI_AWREADY) aw_done_d = 1'b1;
        if (wvalid && M_AXI_WREADY)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          tmo_d     = '0;
        end else if (tmo_hit) begin
          state_d    = FIN;
          err_code_d = EC_TMO;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      RESP: begin
        busy         = 1'b1;
        M_AXI_BREADY = 1'b1;
        tmo_d        = tmo_q + TW'(1);
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP[1]) begin
            state_d    = FIN;
            err_code_d = EC_RESP;
          end else if (last_step) begin
            state_d = FIN;
          end else begin
            state_d = WR;
            step_d  = step_q + 3'd1;
            tmo_d   = '0;
          end
        end else if (tmo_hit) begin
          state_d    = FIN;
          err_code_d = EC_TMO;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q    <= IDLE;
      step_q     <= '0;
      tmo_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      stop_q     <= 1'b0;
      err_code_q <= EC_OK;
      theta_q    <= '0;
      delta_q    <= '0;
      ampl_q     <= '0;
      clkdiv_q   <= '0;
      lngth_q    <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tmo_q      <= tmo_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      stop_q     <= stop_d;
      err_code_q <= err_code_d;
      theta_q    <= theta_d;
      delta_q    <= delta_d;
      ampl_q     <= ampl_d;
      clkdiv_q   <= clkdiv_d;
      lngth_q    <= lngth_d;
    end
  end

  // Address/data are driven only during WR so the bus reads all-zero when idle.
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_AWADDR  = (state_q == WR) ? AW'(XW'(reg_idx) << ADDR_LSB) : '0;
  assign M_AXI_WDATA   = (state_q == WR) ? reg_data : '0;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;
  assign err_code      = err_code_q;
  assign err           = |err_code_q;

endmodule
